// File: rtl/lsu_pkg.sv
// Shared types and constants for the multi-cycle load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] LSU_SIZE_1 = 2'd0;
  localparam logic [1:0] LSU_SIZE_2 = 2'd1;
  localparam logic [1:0] LSU_SIZE_4 = 2'd2;
  localparam logic [1:0] LSU_SIZE_8 = 2'd3;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_low_mask(input logic [1:0] size);
    logic [2:0] m;
    m = 3'b111;
    case (size)
      LSU_SIZE_1: m = 3'b000;
      LSU_SIZE_2: m = 3'b001;
      LSU_SIZE_4: m = 3'b011;
      default:    m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store shift/byte-enable and load extract/extend.
module lsu_align #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [1:0]                      size,
  input  logic                            sign,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
  input  logic [DATA_WIDTH-1:0]           st_data,
  input  logic [DATA_WIDTH-1:0]           ld_word,
  output logic [DATA_WIDTH-1:0]           st_shifted,
  output logic [DATA_WIDTH/8-1:0]         st_mask,
  output logic [DATA_WIDTH-1:0]           ld_result
);
  import lsu_pkg::*;

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  logic [OFF_W+2:0]      bit_off;
  logic [NB-1:0]         base_mask;
  logic [DATA_WIDTH-1:0] ld_shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic [6:0]            nbits;
  logic [IDX_W-1:0]      msb;

  assign bit_off = {off, 3'b000};

  always_comb begin
    base_mask = '0;
    case (size)
      LSU_SIZE_1: base_mask = NB'(8'h01);
      LSU_SIZE_2: base_mask = NB'(8'h03);
      LSU_SIZE_4: base_mask = NB'(8'h0F);
      LSU_SIZE_8: base_mask = NB'(8'hFF);
    endcase
  end

  assign st_shifted = st_data << bit_off;
  assign st_mask    = base_mask << off;

  // Load: bring the addressed bytes to bit 0, keep 2^size bytes, then extend.
  assign ld_shifted = ld_word >> bit_off;
  assign nbits      = 7'd8 << size;
  assign msb        = IDX_W'(nbits - 7'd1);
  assign keep       = (32'(nbits) >= DATA_WIDTH) ? '1 : ~({DATA_WIDTH{1'b1}} << nbits);
  assign ld_result  = (ld_shifted & keep) | ((sign && ld_shifted[msb]) ? ~keep : '0);

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one outstanding access, posted stores,
// registered RAM request and writeback result.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module lsu_mc
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_exu_valid,
  output logic                    o_lsu_ready,
  input  logic                    i_exu_ld,
  input  logic                    i_exu_st,
  input  logic [1:0]              i_exu_size,
  input  logic                    i_exu_sign,
  input  logic [ADDR_WIDTH-1:0]   i_exu_addr,
  input  logic [DATA_WIDTH-1:0]   i_exu_wr_data,
  output logic                    o_ram_req_valid,
  input  logic                    i_ram_req_ready,
  output logic                    o_ram_req_wr,
  output logic [ADDR_WIDTH-1:0]   o_ram_req_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_req_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_ram_req_wr_mask,
  input  logic                    i_ram_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_ram_rsp_data,
  output logic                    o_lsu_valid,
  input  logic                    i_wbu_ready,
  output logic [DATA_WIDTH-1:0]   o_lsu_gpr_wr_data,
  output logic                    o_lsu_err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_e state, state_n;

  logic                  st_r, sign_r;
  logic [1:0]            size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  st_n, sign_n;
  logic [1:0]            size_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;

  logic                  accept;
  logic                  bad;
  logic                  nop;
  logic [DATA_WIDTH-1:0] gpr_n;
  logic                  err_n;
  logic [DATA_WIDTH-1:0] st_shifted;
  logic [NB-1:0]         st_mask;
  logic [DATA_WIDTH-1:0] ld_result;

  assign accept = (state == S_IDLE) && i_exu_valid;
  assign bad    = (|(i_exu_addr[2:0] & size_low_mask(i_exu_size)))
               || ((i_exu_size == LSU_SIZE_8) && (DATA_WIDTH < 64));
  assign nop    = !i_exu_ld && !i_exu_st;

  // Request fields as they will be after this edge; store wins over load.
  always_comb begin
    st_n    = st_r;
    sign_n  = sign_r;
    size_n  = size_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    if (accept) begin
      st_n    = i_exu_st;
      sign_n  = i_exu_sign;
      size_n  = i_exu_size;
      addr_n  = i_exu_addr;
      wdata_n = i_exu_wr_data;
    end
  end

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size       (size_n),
    .sign       (sign_n),
    .off        (addr_n[OFF_W-1:0]),
    .st_data    (wdata_n),
    .ld_word    (i_ram_rsp_data),
    .st_shifted (st_shifted),
    .st_mask    (st_mask),
    .ld_result  (ld_result)
  );

  always_comb begin
    state_n = state;
    gpr_n   = o_lsu_gpr_wr_data;
    err_n   = o_lsu_err;
    case (state)
      S_IDLE: begin
        if (accept) begin
          gpr_n = '0;
          err_n = 1'b0;
          if (bad) begin
            state_n = S_RESP;
            err_n   = 1'b1;
          end else if (nop) begin
            state_n = S_RESP;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_ram_req_ready) begin
          state_n = st_r ? S_RESP : S_WAIT;
          gpr_n   = '0;
          err_n   = 1'b0;
        end
      end
      S_WAIT: begin
        if (i_ram_rsp_valid) begin
          state_n = S_RESP;
          gpr_n   = ld_result;
          err_n   = 1'b0;
        end
      end
      S_RESP: begin
        if (i_wbu_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state <= S_IDLE;
    else           state <= state_n;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      st_r    <= 1'b0;
      sign_r  <= 1'b0;
      size_r  <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      st_r    <= st_n;
      sign_r  <= sign_n;
      size_r  <= size_n;
      addr_r  <= addr_n;
      wdata_r <= wdata_n;
    end
  end

  // Outputs are decoded from the next state so they line up with the state flop.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_lsu_ready       <= 1'b1;
      o_lsu_valid       <= 1'b0;
      o_lsu_gpr_wr_data <= '0;
      o_lsu_err         <= 1'b0;
      o_ram_req_valid   <= 1'b0;
      o_ram_req_wr      <= 1'b0;
      o_ram_req_addr    <= '0;
      o_ram_req_wr_data <= '0;
      o_ram_req_wr_mask <= '0;
    end else begin
      o_lsu_ready       <= (state_n == S_IDLE);
      o_lsu_valid       <= (state_n == S_RESP);
      o_lsu_gpr_wr_data <= (state_n == S_RESP) ? gpr_n : '0;
      o_lsu_err         <= (state_n == S_RESP) && err_n;
      o_ram_req_valid   <= (state_n == S_REQ);
      o_ram_req_wr      <= (state_n == S_REQ) && st_n;
      o_ram_req_addr    <= (state_n == S_REQ) ? {addr_n[ADDR_WIDTH-1:OFF_W], OFF_W'(0)} : '0;
      o_ram_req_wr_data <= ((state_n == S_REQ) && st_n) ? st_shifted : '0;
      o_ram_req_wr_mask <= ((state_n == S_REQ) && st_n) ? st_mask : '0;
    end
  end

endmodule

// File: tb/tb_lsu_mc.sv
// Randomized bench for lsu_mc (64-bit datapath) against a transaction-level model.
module tb_lsu_mc;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          exu_valid, exu_ld, exu_st, exu_sign;
  logic [1:0]    exu_size;
  logic [AW-1:0] exu_addr;
  logic [DW-1:0] exu_wr_data;
  logic          lsu_ready;
  logic          ram_req_valid, ram_req_ready, ram_req_wr;
  logic [AW-1:0] ram_req_addr;
  logic [DW-1:0] ram_req_wr_data;
  logic [7:0]    ram_req_wr_mask;
  logic          ram_rsp_valid;
  logic [DW-1:0] ram_rsp_data;
  logic          lsu_valid, wbu_ready, lsu_err;
  logic [DW-1:0] gpr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_sys_clk         (clk),
    .i_sys_rst         (rst),
    .i_exu_valid       (exu_valid),
    .o_lsu_ready       (lsu_ready),
    .i_exu_ld          (exu_ld),
    .i_exu_st          (exu_st),
    .i_exu_size        (exu_size),
    .i_exu_sign        (exu_sign),
    .i_exu_addr        (exu_addr),
    .i_exu_wr_data     (exu_wr_data),
    .o_ram_req_valid   (ram_req_valid),
    .i_ram_req_ready   (ram_req_ready),
    .o_ram_req_wr      (ram_req_wr),
    .o_ram_req_addr    (ram_req_addr),
    .o_ram_req_wr_data (ram_req_wr_data),
    .o_ram_req_wr_mask (ram_req_wr_mask),
    .i_ram_rsp_valid   (ram_rsp_valid),
    .i_ram_rsp_data    (ram_rsp_data),
    .o_lsu_valid       (lsu_valid),
    .i_wbu_ready       (wbu_ready),
    .o_lsu_gpr_wr_data (gpr),
    .o_lsu_err         (lsu_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference load result: pick 2^size bytes at the byte offset, then extend.
  function automatic logic [63:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [2:0] off, input logic [63:0] word);
    int bytes;
    logic [63:0] v, lowm;
    bytes = 1 << size;
    v = word >> (8 * int'(off));
    if (bytes < 8) begin
      lowm = (64'd1 << (8 * bytes)) - 64'd1;
      v = v & lowm;
      if (sign && v[8*bytes-1]) v = v | ~lowm;
    end
    return v;
  endfunction

  task automatic run_txn(input logic ld, input logic st, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input int req_stall, input int wbu_stall);
    int bytes, off, exp_lat, cyc, stall, wcnt;
    bit err, is_st, is_ld, quiet, done, got_valid, pend;
    logic [63:0] exp_gpr, exp_wdata;
    logic [7:0]  exp_mask;
    logic [31:0] exp_addr;
    bytes    = 1 << size;
    off      = int'(addr[2:0]);
    err      = (int'(addr) % bytes) != 0;
    is_st    = st;
    is_ld    = ld && !st;
    quiet    = err || (!is_st && !is_ld);
    exp_gpr  = (!err && is_ld) ? model_load(size, sign, addr[2:0], rdata) : 64'd0;
    exp_addr = addr & ~32'd7;
    exp_wdata = is_st ? (wdata << (8 * off)) : 64'd0;
    exp_mask  = is_st ? 8'(((bytes == 8) ? 255 : ((1 << bytes) - 1)) << off) : 8'd0;
    exp_lat  = quiet ? 1 : (is_st ? 2 + req_stall : 3 + req_stall);

    @(negedge clk);
    chk("ready_before", 64'(lsu_ready), 64'd1);
    exu_valid = 1'b1; exu_ld = ld; exu_st = st; exu_size = size; exu_sign = sign;
    exu_addr = addr; exu_wr_data = wdata;
    @(posedge clk);
    #1 exu_valid = 1'b0; exu_wr_data = {$urandom, $urandom}; exu_addr = $urandom;
    cyc = 0; stall = 0; wcnt = 0; done = 0; got_valid = 0; pend = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      ram_rsp_valid = 1'b0; ram_req_ready = 1'b0; wbu_ready = 1'b0;
      if (pend) begin
        ram_rsp_valid = 1'b1; ram_rsp_data = rdata; pend = 0;
      end
      chk("busy", 64'(lsu_ready), 64'd0);
      if (quiet) chk("no_ram_req", 64'(ram_req_valid), 64'd0);
      if (ram_req_valid) begin
        chk("req_wr",    64'(ram_req_wr), 64'(is_st));
        chk("req_addr",  64'(ram_req_addr), 64'(exp_addr));
        chk("req_wdata", ram_req_wr_data, exp_wdata);
        chk("req_mask",  64'(ram_req_wr_mask), 64'(exp_mask));
        if (stall < req_stall) begin
          stall++;
          ram_rsp_valid = 1'($urandom_range(0, 1)); ram_rsp_data = {$urandom, $urandom};
        end else begin
          ram_req_ready = 1'b1;
          if (is_ld) pend = 1;
        end
      end else begin
        chk("req_zero", 64'({ram_req_wr, ram_req_wr_mask, |ram_req_addr, |ram_req_wr_data}), 64'd0);
      end
      if (lsu_valid) begin
        if (!got_valid) chk("latency", 64'(cyc), 64'(exp_lat));
        got_valid = 1;
        chk("gpr", gpr, exp_gpr);
        chk("err", 64'(lsu_err), 64'(err));
        if (wcnt < wbu_stall) begin
          wcnt++;
          ram_rsp_valid = 1'b1; ram_rsp_data = {$urandom, $urandom};
        end else begin
          wbu_ready = 1'b1; done = 1;
        end
      end
    end
    chk("timeout", 64'(done), 64'd1);
    @(negedge clk);
    wbu_ready = 1'b0; ram_rsp_valid = 1'b0; ram_req_ready = 1'b0;
    chk("idle_after", 64'({lsu_ready, lsu_valid}), 64'd2);
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    exu_valid = 1'b1; exu_ld = 1'b1; exu_st = 1'b0; exu_size = 2'd3; exu_sign = 1'b0;
    exu_addr = 32'h8000_0010;
    @(posedge clk);
    #1 exu_valid = 1'b0;
    @(negedge clk);
    chk("rw_req", 64'(ram_req_valid), 64'd1);
    ram_req_ready = 1'b1;
    @(posedge clk);
    #1 ram_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_rst_ready", 64'(lsu_ready), 64'd1);
    chk("rw_rst_outs", 64'({lsu_valid, lsu_err, ram_req_valid, |gpr}), 64'd0);
    @(negedge clk);
    rst = 1'b0; ram_rsp_valid = 1'b1; ram_rsp_data = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ram_rsp_valid = 1'b0;
      chk("rw_late_rsp", 64'({lsu_ready, lsu_valid, |gpr}), 64'd4);
    end
  endtask

  initial begin
    rst = 1'b1; exu_valid = 1'b0; exu_ld = 1'b0; exu_st = 1'b0; exu_size = 2'd0;
    exu_sign = 1'b0; exu_addr = '0; exu_wr_data = '0; ram_req_ready = 1'b0;
    ram_rsp_valid = 1'b0; ram_rsp_data = '0; wbu_ready = 1'b0;
    #12;
    chk("rst_ready", 64'(lsu_ready), 64'd1);
    chk("rst_outs", 64'({lsu_valid, lsu_err, ram_req_valid, ram_req_wr, ram_req_wr_mask,
                         |ram_req_addr, |ram_req_wr_data, |gpr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0006, 64'h1234, 64'd0, 0, 0);
    run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'd0, 64'h1111_2222_3333_4444, 0, 0);
    run_txn(1'b0, 1'b1, 2'd3, 1'b0, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'd0, 5, 0);
    run_txn(1'b1, 1'b0, 2'd3, 1'b1, 32'h8000_0010, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 4);
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'd5, 64'd7, 0, 1);
    run_txn(1'b1, 1'b1, 2'd2, 1'b0, 32'h8000_0004, 64'hAABB_CCDD, 64'd0, 1, 0);
    run_txn(1'b1, 1'b0, 2'd1, 1'b1, 32'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 2, 2);
    reset_in_wait();

    for (int i = 0; i < 300; i++) begin
      int r;
      logic l, s;
      r = int'($urandom_range(0, 9));
      l = (r < 5) || (r == 9);
      s = (r >= 5 && r < 9) || (r == 9);
      if (r == 8) begin l = 1'b0; s = 1'b0; end
      run_txn(l, s, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'h8000_0000 | ($urandom & 32'hFF), {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
